// File: rtl/parity_pkg.sv
// Shared definitions for the frame parity monitor: FSM encoding, parity
// polarity constants and the word-parity to LED mapping.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // led[0] lights for odd-popcount words, led[1] for even-popcount words.
    function automatic logic [1:0] led_code(input logic par);
        return (par == PAR_EVEN) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational XOR reduction of one data word: 1 when popcount is odd.
module parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/parity_monitor.sv
// Accumulates parity over FRAME_LEN accepted words and checks it against a
// supplied parity bit. Define PARITY_MONITOR_ERR_CNT_EN to add the err_cnt port.
module parity_monitor
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD_MODE  = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             sw_valid,
    output logic             sw_ready,
    input  logic             par_bit,
    output logic [1:0]       led,
    output logic             frame_done,
    output logic             frame_err
`ifdef PARITY_MONITOR_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int   CW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic TARGET_PAR = (ODD_MODE != 0) ? PAR_ODD : PAR_EVEN;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_word_cnt;
    logic          r_parity;
    logic          r_par_bit;
    logic          w_word_par;
    logic          w_accept;
    logic          w_last_word;
    logic          w_frame_fail;

    parity_calc #(.WIDTH(WIDTH)) u_parity_calc (
        .i_data   (sw),
        .o_parity (w_word_par)
    );

    // r_word_cnt holds the words already taken, so the last word sees FRAME_LEN-1.
    assign w_last_word  = (r_word_cnt == CW'(FRAME_LEN - 1));
    assign w_accept     = sw_valid && sw_ready;
    assign w_frame_fail = ((r_parity ^ r_par_bit) != TARGET_PAR);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        sw_ready     = 1'b1;
        case (r_state)
            IDLE, ACCUM: if (sw_valid) w_next_state = w_last_word ? CHECK : ACCUM;
            CHECK: begin
                sw_ready     = 1'b0;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_parity   <= 1'b0;
            r_par_bit  <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_accept) begin
                led        <= led_code(w_word_par);
                r_parity   <= r_parity ^ w_word_par;
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + CW'(1);
                if (w_last_word) r_par_bit <= par_bit;
            end
            // Acceptance and CHECK never coincide, so the parity clear cannot collide.
            if (r_state == CHECK) begin
                frame_done <= 1'b1;
                frame_err  <= w_frame_fail;
                r_parity   <= 1'b0;
            end
        end
    end

`ifdef PARITY_MONITOR_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == CHECK) && w_frame_fail && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic [CNT_W-1:0] w_unused_err_cnt;
    assign w_unused_err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_monitor.sv
// Directed bench: a default monitor, an ODD_MODE=1 twin and a CNT_W=2 twin
// all see the same stimulus and are checked against hand-computed values.
module tb_parity_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       sw_valid;
    logic       par_bit;

    logic       sw_ready, frame_done, frame_err;
    logic [1:0] led;
    logic       odd_frame_err;
    logic       unused_odd_ready, unused_odd_done, unused_sat_ready, unused_sat_done, unused_sat_err;
    logic [1:0] unused_odd_led, unused_sat_led;
`ifdef PARITY_MONITOR_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic [7:0] unused_odd_cnt;
    logic [1:0] sat_err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int exp_errs = 0;

    logic [7:0] frame_words [4] = '{8'h00, 8'h60, 8'h1C, 8'h55};
    logic [1:0] frame_leds  [4] = '{2'b10, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    parity_monitor u_dut (
        .clk(clk), .rst(rst), .sw(sw), .sw_valid(sw_valid), .sw_ready(sw_ready),
        .par_bit(par_bit), .led(led), .frame_done(frame_done), .frame_err(frame_err)
`ifdef PARITY_MONITOR_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    parity_monitor #(.ODD_MODE(1)) u_odd (
        .clk(clk), .rst(rst), .sw(sw), .sw_valid(sw_valid), .sw_ready(unused_odd_ready),
        .par_bit(par_bit), .led(unused_odd_led), .frame_done(unused_odd_done),
        .frame_err(odd_frame_err)
`ifdef PARITY_MONITOR_ERR_CNT_EN
        , .err_cnt(unused_odd_cnt)
`endif
    );

    parity_monitor #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .sw(sw), .sw_valid(sw_valid), .sw_ready(unused_sat_ready),
        .par_bit(par_bit), .led(unused_sat_led), .frame_done(unused_sat_done),
        .frame_err(unused_sat_err)
`ifdef PARITY_MONITOR_ERR_CNT_EN
        , .err_cnt(sat_err_cnt)
`endif
    );

    always @(negedge clk) if (frame_done) n_done++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic p);
        sw       = w;
        par_bit  = p;
        sw_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    // Frame 00,60,1C,55 has popcount 9 (odd); par_bit is inverted on the
    // non-last words to show it is only sampled with the last one.
    task automatic run_frame(input logic p, input int gap, input logic exp_err);
        int done0;
        done0 = n_done;
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) begin
                sw_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
                check("stall_no_done", frame_done, 1'b0);
            end
            send_word(frame_words[i], (i == 3) ? p : !p);
            check("word_led", led, frame_leds[i]);
        end
        sw = 8'h01;
        check("check_ready", sw_ready, 1'b0);
        check("check_no_done", frame_done, 1'b0);
        @(posedge clk); #1;
        sw_valid = 1'b0;
        check("done_pulse", frame_done, 1'b1);
        check("frame_err", frame_err, exp_err);
        check("odd_frame_err", odd_frame_err, !exp_err);
        check("led_held", led, 2'b10);
        if (exp_err) exp_errs++;
`ifdef PARITY_MONITOR_ERR_CNT_EN
        check("err_cnt", err_cnt, exp_errs);
        check("sat_err_cnt", sat_err_cnt, (exp_errs > 3) ? 3 : exp_errs);
`endif
        @(posedge clk); #1;
        check("done_single", frame_done, 1'b0);
        check("err_held", frame_err, exp_err);
        check("done_count", n_done - done0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        sw       = 8'h00;
        sw_valid = 1'b0;
        par_bit  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", led, 2'b00);
        check("rst_done", frame_done, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_ready", sw_ready, 1'b1);
`ifdef PARITY_MONITOR_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;

        send_word(8'h60, 1'b0);
        check("led_60", led, 2'b10);
        send_word(8'hFB, 1'b0);
        check("led_FB", led, 2'b01);

        sw_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        check("midrst_led", led, 2'b00);
        check("midrst_done", frame_done, 1'b0);
        check("midrst_ready", sw_ready, 1'b1);
        rst = 1'b0;

        run_frame(1'b1, 0, 1'b0);
        run_frame(1'b0, 0, 1'b1);
        run_frame(1'b1, 3, 1'b0);
        for (int k = 0; k < 4; k++) run_frame(1'b0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parity_monitor.md
PARITY_MONITOR -- requirements
Module: parity_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter FRAME_LEN, default 4: number of words per parity frame, minimum 1.
REQ-003 SHALL have parameter ODD_MODE, default 0: 0 selects even frame parity, 1 selects odd frame parity.
REQ-004 SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sw, input, WIDTH bits: data word.
REQ-008 SHALL have port sw_valid, input, 1 bit: sw holds a valid word.
REQ-009 SHALL have port sw_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 SHALL have port par_bit, input, 1 bit: expected frame parity bit, sampled only with the last word of a frame.
REQ-011 SHALL have port led, output, 2 bits: led[0] means the last accepted word has odd parity; led[1] means it has even parity.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame check completes.
REQ-013 SHALL have port frame_err, output, 1 bit: result of the most recent frame check.
REQ-014 SHALL have port err_cnt, output, CNT_W bits, present only when the configuration macro is defined: count of failed frames.

Function
REQ-015 A word SHALL be accepted on a rising edge where sw_valid and sw_ready are both 1.
REQ-016 led SHALL update on the edge that accepts a word: 2'b01 for odd popcount, 2'b10 for even; the value is held until the next accepted word.
REQ-017 The FSM SHALL have the states IDLE, ACCUM and CHECK; sw_ready SHALL be 1 in IDLE and ACCUM and 0 in CHECK.
REQ-018 IDLE SHALL go to ACCUM on acceptance; if FRAME_LEN=1, IDLE SHALL go directly to CHECK.
REQ-019 ACCUM SHALL count accepted words and go to CHECK on acceptance of word FRAME_LEN; with sw_valid=0 it SHALL stall indefinitely, with no timeout.
REQ-020 Running parity SHALL be the XOR of all bits of all accepted words in the frame; it is cleared on entry to IDLE.
REQ-021 CHECK SHALL last exactly one cycle; on its exit edge the block SHALL assert frame_done=1 for one cycle, load frame_err, and return to IDLE.
REQ-022 frame_err SHALL be (running parity XOR par_bit) != ODD_MODE, and SHALL be held until the next frame_done.
REQ-023 Words presented during CHECK SHALL NOT be accepted and SHALL NOT affect any state.
REQ-024 Word latency SHALL be one cycle to led; frame latency SHALL be two cycles from the last acceptance to frame_done.

Reset
REQ-025 While rst=1: the FSM SHALL be in IDLE; the word counter and running parity SHALL be 0; led=2'b00, frame_done=0, frame_err=0, err_cnt=0, sw_ready=1.
REQ-026 A reset in the middle of a frame SHALL discard the partial frame and SHALL NOT produce frame_done.

Configuration
REQ-027 With macro PARITY_MONITOR_ERR_CNT_EN defined, err_cnt SHALL increment by 1 on each frame_done with frame_err=1 and SHALL saturate at 2^CNT_W-1.
REQ-028 Without the macro, the err_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 The package parity_pkg SHALL hold the FSM state encoding (IDLE, ACCUM, CHECK) and the localparams PAR_EVEN=0 and PAR_ODD=1.
REQ-030 The combinational sub-module parity_calc (WIDTH-bit XOR reduction) SHALL be used by the top level.

Verification
Unless stated, WIDTH=8, FRAME_LEN=4, ODD_MODE=0 and the macro is defined.
REQ-031 Reset: hold rst for 2 cycles -> led=00, frame_done=0, frame_err=0, err_cnt=0, sw_ready=1.
REQ-032 Word parity: accept 8'h60 -> led=2'b10 next cycle; accept 8'hFB -> led=2'b01.
REQ-033 Good frame: words 00, 60, 1C, 55 (popcount 9) with par_bit=1 -> sw_ready=0 for one cycle, then frame_done pulse with frame_err=0 and err_cnt unchanged.
REQ-034 Bad frame: the same words with par_bit=0 -> frame_err=1 and err_cnt=1; with ODD_MODE=1 the same frame with par_bit=0 -> frame_err=0.
REQ-035 Stall and reset: 3-cycle sw_valid gaps between words -> same result as REQ-033; rst after 2 words, then a full good frame -> exactly one frame_done, with frame_err=0.
REQ-036 Saturation: CNT_W=2 and 5 consecutive bad frames -> err_cnt=3; without the macro, build and REQ-031 to REQ-035 pass, excluding the err_cnt checks.
